// File: rtl/frame_gen_if.sv
// ---------------------------------------------------------------------------
// frame_gen_if
// Pixel write bus between the test-pattern generator and the TX FIFO.
//
//   fifo_wr_en  master->slave  write strobe, one pixel per asserted cycle
//   fifo_full   slave->master  FIFO cannot accept a write this cycle
//   y_dout      master->slave  [10:0] line number of the offered pixel
//   x_dout      master->slave  [1:0]  {last pixel of line, first pixel of line}
//   dout1       master->slave  [7:0]  {half-line marker, line number[6:0]}
//   dout2       master->slave  [7:0]  pixel index low byte
// ---------------------------------------------------------------------------
interface frame_gen_if;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic [10:0] y_dout;
   logic [1:0]  x_dout;
   logic [7:0]  dout1;
   logic [7:0]  dout2;

   modport master (
      output fifo_wr_en, y_dout, x_dout, dout1, dout2,
      input  fifo_full
   );

   modport slave (
      input  fifo_wr_en, y_dout, x_dout, dout1, dout2,
      output fifo_full
   );
endinterface

// File: rtl/frame_gen.sv
// ---------------------------------------------------------------------------
// frame_gen
// Transmit-side test-pattern source. Streams an H_ACTIVE x V_ACTIVE frame
// into the TX FIFO, one pixel per write, followed by H_BLANK idle cycles per
// line. A one-cycle inject_err pulse flips the half-line marker of a later
// written pixel so the receive-side checker's error counter can be exercised.
//
// Ports:
//   clk125m     in   sole clock
//   reset       in   asynchronous active-low reset
//   enable      in   level; start / keep generating frames
//   inject_err  in   one-cycle pulse; corrupt the marker of a following pixel
//   frame_cnt   out  [7:0] completed frames, wraps
//   busy        out  generator is not idle
//   tx          frame_gen_if.master, FIFO write bus (fifo_wr_en is the only
//               combinational output; all pixel fields are registered)
// ---------------------------------------------------------------------------
module frame_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int H_SPLIT  = 640,
   parameter int H_BLANK  = 16
) (
   input  logic        clk125m,
   input  logic        reset,
   input  logic        enable,
   input  logic        inject_err,
   output logic [7:0]  frame_cnt,
   output logic        busy,
   frame_gen_if.master tx
);

   localparam logic [10:0] PIX_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] LINE_LAST  = 11'(V_ACTIVE - 1);
   localparam logic [10:0] PIX_SPLIT  = 11'(H_SPLIT);
   localparam int          BW         = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
   localparam logic [BW-1:0] BLANK_LAST = BW'((H_BLANK > 0) ? (H_BLANK - 1) : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK} state_t;

   state_t        state_reg, state_next;
   logic [10:0]   pcnt_reg, pcnt_next;
   logic [10:0]   ycnt_reg, ycnt_next;
   logic [BW-1:0] bcnt_reg, bcnt_next;
   logic [7:0]    frame_cnt_reg, frame_cnt_next;
   logic          err_pend_reg, err_pend_next;
   logic          err_mark_reg, err_mark_next;
   logic          busy_reg;
   logic [10:0]   y_dout_reg;
   logic [1:0]    x_dout_reg;
   logic [7:0]    dout1_reg;
   logic [7:0]    dout2_reg;
   logic          rst_sync_reg;
   logic          wr_en;
   logic          load;
   logic          line_done;

   // Assertion reaches every register immediately through this flop's
   // asynchronous clear; release is retimed by one edge so the rest of the
   // design leaves reset cleanly on the following edge.
   always_ff @(posedge clk125m or negedge reset) begin
      if (!reset) rst_sync_reg <= 1'b0;
      else        rst_sync_reg <= 1'b1;
   end

   assign wr_en         = (state_reg == ACTIVE) && !tx.fifo_full;
   assign tx.fifo_wr_en = wr_en;
   assign tx.y_dout     = y_dout_reg;
   assign tx.x_dout     = x_dout_reg;
   assign tx.dout1      = dout1_reg;
   assign tx.dout2      = dout2_reg;
   assign frame_cnt     = frame_cnt_reg;
   assign busy          = busy_reg;

   // Next-state and counter logic. 'load' marks an edge on which a new pixel
   // becomes the offered one, so the registered outputs must be refreshed.
   always_comb begin
      state_next     = state_reg;
      pcnt_next      = pcnt_reg;
      ycnt_next      = ycnt_reg;
      bcnt_next      = bcnt_reg;
      frame_cnt_next = frame_cnt_reg;
      load           = 1'b0;
      line_done      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next = ACTIVE;
               pcnt_next  = '0;
               ycnt_next  = '0;
               load       = 1'b1;
            end
         end
         ACTIVE: begin
            if (wr_en) begin
               if (pcnt_reg == PIX_LAST) begin
                  if (H_BLANK == 0) begin
                     line_done = 1'b1;
                  end else begin
                     state_next = HBLANK;
                     bcnt_next  = '0;
                  end
               end else begin
                  pcnt_next = pcnt_reg + 11'd1;
                  load      = 1'b1;
               end
            end
         end
         HBLANK: begin
            if (bcnt_reg == BLANK_LAST) line_done = 1'b1;
            else                        bcnt_next = bcnt_reg + BW'(1);
         end
         default: state_next = IDLE;
      endcase

      if (line_done) begin
         pcnt_next = '0;
         if (ycnt_reg == LINE_LAST) begin
            ycnt_next      = '0;
            frame_cnt_next = frame_cnt_reg + 8'd1;
            if (enable) begin
               state_next = ACTIVE;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end else begin
            ycnt_next  = ycnt_reg + 11'd1;
            state_next = ACTIVE;
            load       = 1'b1;
         end
      end
   end

   // err_pend stays set from the pulse until the corrupted pixel is written.
   // err_mark tags the currently offered pixel as the corrupted one; the
   // corruption is bound to the next pixel loaded after the pulse, so a pulse
   // coinciding with a write lands on the following pixel.
   always_comb begin
      err_pend_next = (wr_en && err_mark_reg) ? 1'b0 : (err_pend_reg | inject_err);
      err_mark_next = err_mark_reg;
      if (load)       err_mark_next = err_pend_next;
      else if (wr_en) err_mark_next = 1'b0;
   end

   always_ff @(posedge clk125m or negedge rst_sync_reg) begin
      if (!rst_sync_reg) begin
         state_reg     <= IDLE;
         pcnt_reg      <= '0;
         ycnt_reg      <= '0;
         bcnt_reg      <= '0;
         frame_cnt_reg <= '0;
         err_pend_reg  <= 1'b0;
         err_mark_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         y_dout_reg    <= '0;
         x_dout_reg    <= '0;
         dout1_reg     <= '0;
         dout2_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         pcnt_reg      <= pcnt_next;
         ycnt_reg      <= ycnt_next;
         bcnt_reg      <= bcnt_next;
         frame_cnt_reg <= frame_cnt_next;
         err_pend_reg  <= err_pend_next;
         err_mark_reg  <= err_mark_next;
         busy_reg      <= (state_next != IDLE);
         if (load) begin
            y_dout_reg <= ycnt_next;
            x_dout_reg <= {pcnt_next == PIX_LAST, pcnt_next == 11'd0};
            dout1_reg  <= {(pcnt_next >= PIX_SPLIT) ^ err_pend_next, ycnt_next[6:0]};
            dout2_reg  <= pcnt_next[7:0];
         end
      end
   end

endmodule
